// File: rtl/qam16_pkg.sv
// Shared 16-QAM definitions: sample width, default amplitudes, payload types and the Gray map.
package qam16_pkg;

    localparam int unsigned SAMPLE_W   = 18;
    localparam int unsigned SYM_W      = 4;
    localparam int unsigned UF_CNT_W   = 16;

    localparam logic signed [SAMPLE_W-1:0] LEVEL_1_DEF = 18'sd32768;
    localparam logic signed [SAMPLE_W-1:0] LEVEL_3_DEF = 18'sd98304;

    typedef struct packed {
        logic [1:0] i_bits;
        logic [1:0] q_bits;
    } sym_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] i;
        logic signed [SAMPLE_W-1:0] q;
    } iq_t;

    typedef enum logic [1:0] {
        SLOT_NONE  = 2'd0,
        SLOT_SYM   = 2'd1,
        SLOT_UNDER = 2'd2
    } slot_e;

    // Bit 1 selects the sign, bit 0 selects the inner level (Gray order -3,-1,+1,+3).
    function automatic logic signed [SAMPLE_W-1:0] gray_map(
        input logic [1:0]                 bits,
        input logic signed [SAMPLE_W-1:0] lvl1,
        input logic signed [SAMPLE_W-1:0] lvl3
    );
        logic signed [SAMPLE_W-1:0] mag;
        mag = bits[0] ? lvl1 : lvl3;
        return bits[1] ? mag : -mag;
    endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry symbol FIFO with a registered ready flag that never looks ahead to a same-cycle pop.
module sym_fifo2
    import qam16_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_pop,
    input  sym_t i_data,
    output sym_t o_data_c,
    output logic o_empty_c,
    output logic o_full_c,
    output logic o_ready
);

    sym_t       r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       r_ready;

    logic       w_do_push;
    logic       w_do_pop;
    logic [1:0] w_count_nxt;

    assign o_empty_c = (r_count == 2'd0);
    assign o_full_c  = (r_count == 2'd2);
    assign o_data_c  = r_mem[r_rd_ptr];
    assign o_ready   = r_ready;

    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Ready is low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/qam16_map_upsample.sv
// 16-QAM Gray mapper with zero-stuffing to SPS samples per symbol; feeds the I/Q pulse-shaping FIRs.
module qam16_map_upsample
    import qam16_pkg::*;
#(
    parameter int unsigned                SPS     = 4,
    parameter logic signed [SAMPLE_W-1:0] LEVEL_1 = LEVEL_1_DEF,
    parameter logic signed [SAMPLE_W-1:0] LEVEL_3 = LEVEL_3_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [SYM_W-1:0]           sym_in,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    output logic signed [SAMPLE_W-1:0] out_i,
    output logic signed [SAMPLE_W-1:0] out_q,
    output logic                       sym_strobe,
    output logic                       underflow,
    output logic [UF_CNT_W-1:0]        underflow_cnt
);

    localparam int unsigned   PH_W    = $clog2(SPS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

    logic [PH_W-1:0]     r_phase;
    iq_t                 r_out;
    logic                r_strobe;
    logic                r_underflow;
    logic [UF_CNT_W-1:0] r_underflow_cnt;

    logic                w_fifo_ready;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    sym_t                w_head;
    logic                w_push;
    logic                w_pop;
    slot_e               w_slot;

    logic [PH_W-1:0]     w_phase_nxt;
    iq_t                 w_out_nxt;
    logic                w_strobe_nxt;
    logic                w_underflow_nxt;
    logic [UF_CNT_W-1:0] w_underflow_cnt_nxt;

    assign w_push = sym_valid && w_fifo_ready;
    assign w_pop  = (w_slot == SLOT_SYM);

    sym_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (sym_t'(sym_in)),
        .o_data_c  (w_head),
        .o_empty_c (w_fifo_empty),
        .o_full_c  (w_fifo_full),
        .o_ready   (w_fifo_ready)
    );

    // A symbol slot opens on an enabled phase-0 cycle; an empty FIFO there is an underflow.
    always_comb begin
        w_slot = SLOT_NONE;
        if (en && (r_phase == '0)) begin
            w_slot = w_fifo_empty ? SLOT_UNDER : SLOT_SYM;
        end
    end

    always_comb begin
        w_phase_nxt         = r_phase;
        w_out_nxt           = '0;
        w_strobe_nxt        = 1'b0;
        w_underflow_nxt     = 1'b0;
        w_underflow_cnt_nxt = r_underflow_cnt;

        if (en) begin
            w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
        end

        case (w_slot)
            SLOT_SYM: begin
                w_out_nxt.i  = gray_map(w_head.i_bits, LEVEL_1, LEVEL_3);
                w_out_nxt.q  = gray_map(w_head.q_bits, LEVEL_1, LEVEL_3);
                w_strobe_nxt = 1'b1;
            end
            SLOT_UNDER: begin
                w_underflow_nxt = 1'b1;
                if (r_underflow_cnt != '1) begin
                    w_underflow_cnt_nxt = r_underflow_cnt + UF_CNT_W'(1);
                end
            end
            default: begin
                w_underflow_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase         <= '0;
            r_out           <= '0;
            r_strobe        <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_phase         <= w_phase_nxt;
            r_out           <= w_out_nxt;
            r_strobe        <= w_strobe_nxt;
            r_underflow     <= w_underflow_nxt;
            r_underflow_cnt <= w_underflow_cnt_nxt;
        end
    end

    assign sym_ready     = w_fifo_ready;
    assign out_i         = r_out.i;
    assign out_q         = r_out.q;
    assign sym_strobe    = r_strobe;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_qam16_map_upsample.sv
// Directed bench for qam16_map_upsample (SPS=4): mapping, zero-stuffing, backpressure, underflow, stall, reset.
module tb_qam16_map_upsample;

    localparam logic signed [17:0] P3 = 18'sd98304;
    localparam logic signed [17:0] P1 = 18'sd32768;
    localparam logic signed [17:0] N1 = -18'sd32768;
    localparam logic signed [17:0] N3 = -18'sd98304;
    localparam logic signed [17:0] Z  = 18'sd0;

    logic               clk;
    logic               reset;
    logic               en;
    logic [3:0]         sym_in;
    logic               sym_valid;
    logic               sym_ready;
    logic signed [17:0] out_i;
    logic signed [17:0] out_q;
    logic               sym_strobe;
    logic               underflow;
    logic [15:0]        underflow_cnt;

    int n_checks;
    int n_err;
    int ph;
    int idx;
    int n_strobe;
    int nuf;
    logic [3:0] syms [8];
    logic [3:0] exp_q [$];

    qam16_map_upsample #(.SPS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .sym_in        (sym_in),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .out_i         (out_i),
        .out_q         (out_q),
        .sym_strobe    (sym_strobe),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [17:0] lvl(input logic [1:0] b);
        case (b)
            2'b00:   return N3;
            2'b01:   return N1;
            2'b11:   return P1;
            default: return P3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model phase advances on enabled edges; returns at the negedge for sampling.
    task automatic step();
        @(posedge clk);
        if (reset) ph = 0;
        else if (en) ph = (ph + 1) % 4;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_i"}, out_i, Z);
        chk({tag, "_q"}, out_q, Z);
        chk({tag, "_stb"}, {31'd0, sym_strobe}, 32'd0);
    endtask

    // Step with scoreboard: record accepted symbols, match every impulse against the oldest one.
    task automatic step_sb();
        logic       p;
        logic [3:0] e;
        p = sym_valid && sym_ready;
        if (p) exp_q.push_back(sym_in);
        step();
        if (p) begin
            idx++;
            if (idx < 8) sym_in = syms[idx];
            else sym_valid = 1'b0;
        end
        chk("sb_uf", {31'd0, underflow}, 32'd0);
        if (sym_strobe) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                chk("sb_extra_strobe", {31'd0, sym_strobe}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_i", out_i, lvl(e[3:2]));
                chk("sb_q", out_q, lvl(e[1:0]));
            end
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0; ph = 0; idx = 0; n_strobe = 0; nuf = 0;
        syms[0] = 4'b1000; syms[1] = 4'b0111; syms[2] = 4'b0000; syms[3] = 4'b1111;
        syms[4] = 4'b0101; syms[5] = 4'b1010; syms[6] = 4'b0010; syms[7] = 4'b1101;
        reset = 1'b1; en = 1'b0; sym_in = 4'd0; sym_valid = 1'b0;

        // 1: reset for 5 cycles, release, first edge after release
        repeat (5) step();
        chk("rst_ready", {31'd0, sym_ready}, 32'd0);
        chk_zero("rst_out");
        reset = 1'b0;
        chk("rel_ready_pre", {31'd0, sym_ready}, 32'd0);
        step();
        chk("rel_ready", {31'd0, sym_ready}, 32'd1);
        chk_zero("rel_out");
        chk("rel_uf", {31'd0, underflow}, 32'd0);
        chk("rel_ufcnt", {16'd0, underflow_cnt}, 32'd0);

        // 2: two symbols, impulse then three zeros each
        sym_valid = 1'b1; sym_in = 4'b1000;
        step();
        sym_in = 4'b0111;
        step();
        chk("t2_full_ready", {31'd0, sym_ready}, 32'd0);
        sym_valid = 1'b0; en = 1'b1;
        step();
        chk("t2_s0_i", out_i, P3);
        chk("t2_s0_q", out_q, N3);
        chk("t2_s0_stb", {31'd0, sym_strobe}, 32'd1);
        repeat (3) begin step(); chk_zero("t2_gap0"); end
        step();
        chk("t2_s1_i", out_i, N1);
        chk("t2_s1_q", out_q, P1);
        chk("t2_s1_stb", {31'd0, sym_strobe}, 32'd1);
        repeat (3) begin
            step(); chk_zero("t2_gap1");
            chk("t2_uf", {31'd0, underflow}, 32'd0);
        end
        en = 1'b0;
        chk("t2_ufcnt", {16'd0, underflow_cnt}, 32'd0);

        // 3: continuous valid, backpressure and scoreboard
        idx = 0; sym_in = syms[0]; sym_valid = 1'b1;
        step_sb();
        step_sb();
        chk("t3_ready_drop", {31'd0, sym_ready}, 32'd0);
        step_sb();
        chk("t3_ready_hold", {31'd0, sym_ready}, 32'd0);
        en = 1'b1;
        step_sb();
        chk("t3_ready_pop", {31'd0, sym_ready}, 32'd1);
        for (int c = 0; c < 200 && !(idx == 8 && exp_q.size() == 0 && ph == 0); c++) step_sb();
        en = 1'b0;
        chk("t3_all_sent", idx, 8);
        chk("t3_n_strobe", n_strobe, 8);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: starve for 3 slots, then saturate the counter
        en = 1'b1;
        repeat (12) begin
            step();
            if (underflow) nuf++;
            chk_zero("t4_starve");
        end
        en = 1'b0;
        chk("t4_nuf", nuf, 3);
        chk("t4_ufcnt", {16'd0, underflow_cnt}, 32'd3);
        force dut.r_underflow_cnt = 16'hFFFF;
        step();
        release dut.r_underflow_cnt;
        chk("t4_forced", {16'd0, underflow_cnt}, 32'h0000FFFF);
        en = 1'b1;
        step();
        chk("t4_sat_uf", {31'd0, underflow}, 32'd1);
        chk("t4_sat_cnt", {16'd0, underflow_cnt}, 32'h0000FFFF);
        repeat (3) step();
        en = 1'b0;

        // 5: stall 7 cycles at phase 2
        sym_valid = 1'b1; sym_in = 4'b1111;
        step();
        sym_in = 4'b0101;
        step();
        sym_valid = 1'b0; en = 1'b1;
        step();
        chk("t5_s0_i", out_i, P1);
        chk("t5_s0_q", out_q, P1);
        step();
        en = 1'b0;
        repeat (7) begin
            step(); chk_zero("t5_stall");
            chk("t5_stall_uf", {31'd0, underflow}, 32'd0);
        end
        en = 1'b1;
        step(); chk_zero("t5_resume1");
        step(); chk_zero("t5_resume2");
        step();
        chk("t5_s1_stb", {31'd0, sym_strobe}, 32'd1);
        chk("t5_s1_i", out_i, N1);
        chk("t5_s1_q", out_q, N1);
        repeat (3) step();
        en = 1'b0;

        // 6: async reset with two symbols buffered at phase 1
        sym_valid = 1'b1; sym_in = 4'b0000;
        step();
        en = 1'b1; sym_in = 4'b1111;
        step();
        chk("t6_d_i", out_i, N3);
        chk("t6_d_q", out_q, N3);
        en = 1'b0; sym_in = 4'b0010;
        step();
        sym_valid = 1'b0;
        chk("t6_full", {31'd0, sym_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_cnt", {16'd0, underflow_cnt}, 32'd0);
        chk("t6_async_ready", {31'd0, sym_ready}, 32'd0);
        chk_zero("t6_async_out");
        step();
        step();
        reset = 1'b0;
        sym_valid = 1'b1; sym_in = 4'b1010;
        step();
        chk("t6_rel_ready", {31'd0, sym_ready}, 32'd1);
        step();
        sym_valid = 1'b0; en = 1'b1;
        step();
        chk("t6_g_stb", {31'd0, sym_strobe}, 32'd1);
        chk("t6_g_i", out_i, P3);
        chk("t6_g_q", out_q, P3);
        chk("t6_cnt", {16'd0, underflow_cnt}, 32'd0);
        repeat (3) step();
        en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
